// File: rtl/data_in_mux_pkg.sv
// data_in_pkg: shared defaults and helpers for the data_in_mux acquisition
// front-end.
//   DEF_N_CH / DEF_DATA_W / DEF_MAX_DEC_LOG2 : default widths and the limit
//                                               on the decimation exponent
//   mode_e                                   : MODE_SINGLE / MODE_SCAN
//   ch_offset()                              : LSB of a channel slice inside
//                                               the packed sample bus
package data_in_pkg;

  localparam int unsigned DEF_N_CH         = 4;
  localparam int unsigned DEF_DATA_W       = 16;
  localparam int unsigned DEF_MAX_DEC_LOG2 = 8;

  typedef enum logic {
    MODE_SINGLE = 1'b0,
    MODE_SCAN   = 1'b1
  } mode_e;

  function automatic int unsigned ch_offset(input int unsigned ch,
                                            input int unsigned data_w);
    return ch * data_w;
  endfunction

endpackage

// File: rtl/data_in_mux_if.sv
// data_in_mux_if: sample bus between the source drivers and data_in_mux.
//   in_data   : packed samples, channel i at [i*DATA_W +: DATA_W]
//   in_valid  : per-channel sample strobe
//   out_data  : selected / multiplexed output sample
//   out_ch    : source channel of out_data
//   out_valid : one-cycle strobe per output sample
// master = source/consumer side, slave = data_in_mux side.
interface data_in_mux_if #(
  parameter int unsigned N_CH   = 4,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned CH_W   = $clog2(N_CH)
);

  logic [N_CH*DATA_W-1:0] in_data;
  logic [N_CH-1:0]        in_valid;
  logic [DATA_W-1:0]      out_data;
  logic [CH_W-1:0]        out_ch;
  logic                   out_valid;

  modport master (
    output in_data, in_valid,
    input  out_data, out_ch, out_valid
  );

  modport slave (
    input  in_data, in_valid,
    output out_data, out_ch, out_valid
  );

endinterface

// File: rtl/data_in_mux_decimator.sv
// data_in_decimator: per-channel power-of-two decimator.
//   clk, reset_n : clock, asynchronous active-low reset
//   clr          : synchronous clear (run stopped or channel inactive)
//   dec_log2     : group size K = 2^dec_log2 (already saturated)
//   in_valid     : sample strobe, in_data : sample
//   grant        : arbiter took the held result this cycle
//   hold         : held result, pending : hold not yet granted
//   new_result   : a result completes this cycle
// Build option DATA_IN_MUX_AVG_EN: result is the floored group mean instead
// of the last sample of the group.
module data_in_decimator #(
  parameter int unsigned DATA_W       = 16,
  parameter int unsigned MAX_DEC_LOG2 = 8,
  parameter int unsigned DEC_W        = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clr,
  input  logic [DEC_W-1:0]  dec_log2,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              grant,
  output logic [DATA_W-1:0] hold,
  output logic              pending,
  output logic              new_result
);

  localparam int unsigned CNT_W = MAX_DEC_LOG2;

  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  lim;
  logic              last;
  logic [DATA_W-1:0] result;

  // lim = K-1 as a run of dec_log2 ones
  always_comb begin
    lim = '0;
    for (int unsigned b = 0; b < CNT_W; b++) begin
      lim[b] = (b < 32'(dec_log2));
    end
  end

  assign last       = in_valid && !clr && (cnt == lim);
  assign new_result = last;

`ifdef DATA_IN_MUX_AVG_EN
  localparam int unsigned ACC_W = DATA_W + MAX_DEC_LOG2;

  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] sum;

  assign sum    = acc + $signed({{MAX_DEC_LOG2{in_data[DATA_W-1]}}, in_data});
  // >>> on a signed value floors toward -inf
  assign result = DATA_W'(sum >>> dec_log2);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (in_valid) begin
      acc <= last ? '0 : sum;
    end
  end
`else
  assign result = in_data;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt     <= '0;
      hold    <= '0;
      pending <= 1'b0;
    end else if (clr) begin
      cnt     <= '0;
      hold    <= '0;
      pending <= 1'b0;
    end else begin
      if (in_valid) begin
        cnt <= last ? '0 : cnt + CNT_W'(1);
      end
      // a fresh result wins over a same-cycle grant, keeping pending set
      if (last) begin
        hold    <= result;
        pending <= 1'b1;
      end else if (grant) begin
        pending <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/data_in_mux.sv
// data_in_mux: multi-channel acquisition front-end.
//   clk, reset_n   : clock, asynchronous active-low reset
//   enable         : run; while low config is loaded and datapath cleared
//   mode           : 0 single channel, 1 round-robin scan
//   sel_ch         : channel forwarded in single mode
//   ch_mask        : channels enabled in scan mode
//   decim_log2     : decimation exponent (saturates at MAX_DEC_LOG2)
//   clear_overrun  : synchronous clear of overrun (a same-cycle set wins)
//   bus            : data_in_mux_if.slave (in_data/in_valid/out_*)
//   overrun        : sticky per-channel loss flags
// Build option DATA_IN_MUX_AVG_EN selects averaging decimators.
module data_in_mux
  import data_in_pkg::*;
#(
  parameter int unsigned N_CH         = DEF_N_CH,
  parameter int unsigned DATA_W       = DEF_DATA_W,
  parameter int unsigned MAX_DEC_LOG2 = DEF_MAX_DEC_LOG2,
  parameter int unsigned CH_W         = $clog2(N_CH),
  parameter int unsigned DEC_W        = $clog2(MAX_DEC_LOG2 + 1)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               enable,
  input  logic               mode,
  input  logic [CH_W-1:0]    sel_ch,
  input  logic [N_CH-1:0]    ch_mask,
  input  logic [DEC_W-1:0]   decim_log2,
  input  logic               clear_overrun,
  data_in_mux_if.slave       bus,
  output logic [N_CH-1:0]    overrun
);

  localparam logic [DEC_W-1:0] DEC_MAX = DEC_W'(MAX_DEC_LOG2);

  mode_e             mode_r;
  logic [CH_W-1:0]   sel_r;
  logic [N_CH-1:0]   mask_r;
  logic [DEC_W-1:0]  dec_r;

  logic [N_CH-1:0]   active;
  logic [N_CH-1:0]   pending;
  logic [N_CH-1:0]   new_res;
  logic [N_CH-1:0]   grant;
  logic [N_CH-1:0]   ov_set;
  logic [DATA_W-1:0] hold [N_CH];

  logic [CH_W-1:0]   ptr;
  logic [CH_W-1:0]   gnt_idx;
  logic [CH_W-1:0]   ptr_next;
  logic              gnt_any;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_r <= MODE_SINGLE;
      sel_r  <= '0;
      mask_r <= '0;
      dec_r  <= '0;
    end else if (!enable) begin
      mode_r <= mode_e'(mode);
      sel_r  <= sel_ch;
      mask_r <= ch_mask;
      dec_r  <= (decim_log2 > DEC_MAX) ? DEC_MAX : decim_log2;
    end
  end

  // sel_ch values >= N_CH match no channel, leaving the block idle
  always_comb begin
    active = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      active[i] = (mode_r == MODE_SCAN) ? mask_r[i] : (sel_r == CH_W'(i));
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    data_in_decimator #(
      .DATA_W       (DATA_W),
      .MAX_DEC_LOG2 (MAX_DEC_LOG2),
      .DEC_W        (DEC_W)
    ) u_dec (
      .clk        (clk),
      .reset_n    (reset_n),
      .clr        (!enable || !active[g]),
      .dec_log2   (dec_r),
      .in_valid   (bus.in_valid[g]),
      .in_data    (bus.in_data[ch_offset(g, DATA_W) +: DATA_W]),
      .grant      (grant[g]),
      .hold       (hold[g]),
      .pending    (pending[g]),
      .new_result (new_res[g])
    );
  end

  // Single mode has only one requester, so the same rotating search serves
  // both modes; the pointer only advances in scan mode.
  always_comb begin
    int unsigned idx;
    logic [CH_W-1:0] cand;
    idx     = 0;
    cand    = '0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      idx  = (32'(ptr) + k) % N_CH;
      cand = CH_W'(idx);
      if (!gnt_any && pending[cand] && active[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
    grant = '0;
    if (gnt_any) begin
      grant[gnt_idx] = 1'b1;
    end
  end

  assign ptr_next = (gnt_idx == CH_W'(N_CH - 1)) ? '0 : gnt_idx + CH_W'(1);
  assign ov_set   = new_res & pending & ~grant;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.out_data  <= '0;
      bus.out_ch    <= '0;
      bus.out_valid <= 1'b0;
      ptr           <= '0;
      overrun       <= '0;
    end else begin
      if (!enable) begin
        bus.out_valid <= 1'b0;
        ptr           <= '0;
      end else begin
        bus.out_valid <= gnt_any;
        if (gnt_any) begin
          bus.out_data <= hold[gnt_idx];
          bus.out_ch   <= gnt_idx;
          if (mode_r == MODE_SCAN) begin
            ptr <= ptr_next;
          end
        end
      end
      overrun <= (clear_overrun ? '0 : overrun) | ov_set;
    end
  end

endmodule

// File: tb/tb_data_in_mux.sv
// Testbench for data_in_mux: directed scenarios with literal expectations
// plus randomized runs compared every cycle against a behavioural model.
module tb_data_in_mux;

  localparam int unsigned N  = 4;
  localparam int unsigned W  = 16;
  localparam int unsigned MD = 8;
  localparam int unsigned CW = 2;
  localparam int unsigned DW = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic          enable = 1'b0;
  logic          mode = 1'b0;
  logic          clear_overrun = 1'b0;
  logic [CW-1:0] sel_ch = '0;
  logic [N-1:0]  ch_mask = '0;
  logic [DW-1:0] decim_log2 = '0;
  logic [N-1:0]  overrun;

  data_in_mux_if #(.N_CH(N), .DATA_W(W), .CH_W(CW)) dif ();

  data_in_mux #(
    .N_CH(N), .DATA_W(W), .MAX_DEC_LOG2(MD), .CH_W(CW), .DEC_W(DW)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .enable        (enable),
    .mode          (mode),
    .sel_ch        (sel_ch),
    .ch_mask       (ch_mask),
    .decim_log2    (decim_log2),
    .clear_overrun (clear_overrun),
    .bus           (dif.slave),
    .overrun       (overrun)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int           m_mode, m_sel, m_dec, m_ptr;
  logic [N-1:0] m_mask, m_ov;
  int           m_cnt [N];
  longint       m_sum [N];
  bit           m_pend[N];
  logic [W-1:0] m_val [N];
  bit           e_valid;
  logic [W-1:0] e_data;
  int           e_ch;

  task automatic model_reset();
    m_mode = 0; m_sel = 0; m_dec = 0; m_ptr = 0; m_mask = '0; m_ov = '0;
    e_valid = 0; e_data = '0; e_ch = 0;
    for (int i = 0; i < N; i++) begin
      m_cnt[i] = 0; m_sum[i] = 0; m_pend[i] = 0; m_val[i] = '0;
    end
  endtask

  task automatic model_step();
    bit           act[N];
    int           g;
    int           k_size;
    longint       x, q;
    logic [N-1:0] set;
    set = '0;
    if (!enable) begin
      for (int i = 0; i < N; i++) begin
        m_cnt[i] = 0; m_sum[i] = 0; m_pend[i] = 0;
      end
      m_ptr   = 0;
      e_valid = 0;
      m_ov    = clear_overrun ? '0 : m_ov;
      m_mode  = int'(mode);
      m_sel   = int'(sel_ch);
      m_mask  = ch_mask;
      m_dec   = (int'(decim_log2) > MD) ? MD : int'(decim_log2);
      return;
    end
    for (int i = 0; i < N; i++) act[i] = m_mode ? m_mask[i] : (m_sel == i);
    g = -1;
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = m_mode ? (m_ptr + k) % N : m_sel;
      if (g < 0 && idx < N && act[idx] && m_pend[idx]) g = idx;
    end
    e_valid = (g >= 0);
    if (g >= 0) begin
      e_data = m_val[g];
      e_ch   = g;
      if (m_mode) m_ptr = (g + 1) % N;
    end
    k_size = 1 << m_dec;
    for (int i = 0; i < N; i++) begin
      bit done;
      done = 0;
      if (act[i] && dif.in_valid[i]) begin
        x = longint'($signed(dif.in_data[i*W +: W]));
        m_cnt[i]++;
        m_sum[i] += x;
        if (m_cnt[i] == k_size) begin
`ifdef DATA_IN_MUX_AVG_EN
          q = m_sum[i] / k_size;
          if ((m_sum[i] % k_size) != 0 && m_sum[i] < 0) q = q - 1;
`else
          q = x;
`endif
          if (m_pend[i] && g != i) set[i] = 1'b1;
          m_pend[i] = 1;
          m_val[i]  = W'(q);
          m_cnt[i]  = 0;
          m_sum[i]  = 0;
          done      = 1;
        end
      end
      if (!done && g == i) m_pend[i] = 0;
    end
    m_ov = (clear_overrun ? '0 : m_ov) | set;
  endtask

  always @(negedge reset_n) model_reset();
  always @(posedge clk) if (reset_n) model_step();

  // every-cycle comparison against the model
  always @(negedge clk) begin
    check("out_valid", dif.out_valid, e_valid);
    if (e_valid) begin
      check("out_data", dif.out_data, e_data);
      check("out_ch", dif.out_ch, e_ch);
    end
    check("overrun", overrun, m_ov);
  end

  // output monitor for the directed scenarios
  typedef struct { int cyc; logic [W-1:0] d; int ch; } obs_t;
  obs_t obs[$];
  int   cyc = 0;
  always @(posedge clk) cyc++;
  always @(negedge clk)
    if (dif.out_valid) obs.push_back('{cyc, dif.out_data, int'(dif.out_ch)});

  // ---------------- stimulus helpers ----------------
  task automatic configure(input bit m, input int s, input logic [N-1:0] msk,
                           input int d);
    @(negedge clk);
    enable = 0; dif.in_valid = '0;
    mode = m; sel_ch = CW'(s); ch_mask = msk; decim_log2 = DW'(d);
    repeat (2) @(negedge clk);
    enable = 1;
  endtask

  task automatic drive1(input int ch, input logic [W-1:0] v);
    @(negedge clk);
    dif.in_valid = '0;
    dif.in_valid[ch] = 1'b1;
    dif.in_data[ch*W +: W] = v;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      dif.in_valid = '0;
    end
  endtask

  int c0;
  int exp_seq[3] = '{0, 1, 3};

  initial begin
    dif.in_valid = '0;
    dif.in_data  = '0;
    #1 reset_n = 0;
    #20 reset_n = 1;

    // single mode, K=1, constant 100 on ch1
    configure(0, 1, '0, 0);
    obs.delete();
    @(negedge clk);
    dif.in_valid = 4'b0010; dif.in_data[W +: W] = 16'd100; c0 = cyc + 1;
    repeat (4) @(negedge clk);
    idle(4);
    check("t1_count", obs.size(), 5);
    for (int k = 0; k < obs.size(); k++) begin
      check("t1_cyc", obs[k].cyc, c0 + 1 + k);
      check("t1_data", obs[k].d, 16'd100);
      check("t1_ch", obs[k].ch, 1);
    end
    check("t1_overrun", overrun, 4'b0000);

    // K=4 group 1,2,3,6
    configure(0, 0, '0, 2);
    obs.delete();
    drive1(0, 16'd1); drive1(0, 16'd2); drive1(0, 16'd3); drive1(0, 16'd6);
    idle(4);
    check("t2_count", obs.size(), 1);
`ifdef DATA_IN_MUX_AVG_EN
    if (obs.size() > 0) check("t2_data", obs[0].d, 16'd3);
`else
    if (obs.size() > 0) check("t2_data", obs[0].d, 16'd6);
`endif

    // K=2: -3,-4 then 32767,32767
    configure(0, 2, '0, 1);
    obs.delete();
    drive1(2, 16'hFFFD); drive1(2, 16'hFFFC);
    idle(4);
    check("t3_count", obs.size(), 1);
    if (obs.size() > 0) check("t3_neg", obs[0].d, 16'hFFFC);
    obs.delete();
    drive1(2, 16'h7FFF); drive1(2, 16'h7FFF);
    idle(4);
    check("t3b_count", obs.size(), 1);
    if (obs.size() > 0) check("t3_max", obs[0].d, 16'h7FFF);

    // scan, mask 1011, all four strobed together every 4 clk
    configure(1, 0, 4'b1011, 0);
    obs.delete();
    for (int r = 0; r < 3; r++) begin
      @(negedge clk);
      dif.in_valid = 4'b1111;
      dif.in_data  = {$urandom, $urandom};
      idle(3);
    end
    idle(3);
    check("t4_count", obs.size(), 9);
    for (int k = 0; k < obs.size(); k++) check("t4_order", obs[k].ch, exp_seq[k % 3]);
    check("t4_overrun", overrun, 4'b0000);

    // scan, all channels every clk: overrun saturates, clear, re-set
    configure(1, 0, 4'b1111, 0);
    repeat (6) begin
      @(negedge clk);
      dif.in_valid = 4'b1111;
      dif.in_data  = 64'h1234_5678_9ABC_DEF1;
    end
    @(negedge clk);
    check("t5_full", overrun, 4'b1111);
    dif.in_valid = '0; clear_overrun = 1;
    @(negedge clk);
    check("t5_clear", overrun, 4'b0000);
    clear_overrun = 0; dif.in_valid = 4'b1111;
    repeat (4) @(negedge clk);
    check("t5_reset", overrun, 4'b1111);
    clear_overrun = 1;
    @(negedge clk);
    clear_overrun = 0;
    idle(3);

    // async reset mid-group
    configure(0, 0, '0, 2);
    obs.delete();
    drive1(0, 16'd5); drive1(0, 16'd7);
    @(posedge clk);
    #2 reset_n = 0; dif.in_valid = '0;
    #1;
    check("t6_valid", dif.out_valid, 1'b0);
    check("t6_data", dif.out_data, 16'd0);
    check("t6_ch", dif.out_ch, 0);
    check("t6_overrun", overrun, 4'b0000);
    #20 reset_n = 1;
    configure(0, 0, '0, 2);
    obs.delete();
    drive1(0, 16'd9); drive1(0, 16'd9); drive1(0, 16'd9);
    idle(4);
    check("t6_none", obs.size(), 0);
    drive1(0, 16'd11);
    idle(4);
    check("t6_one", obs.size(), 1);
`ifdef DATA_IN_MUX_AVG_EN
    if (obs.size() > 0) check("t6_data_out", obs[0].d, 16'd9);
`else
    if (obs.size() > 0) check("t6_data_out", obs[0].d, 16'd11);
`endif

    // randomized runs against the model
    for (int t = 0; t < 12; t++) begin
      int dec, dens;
      dec  = ($urandom_range(0, 9) == 0) ? $urandom_range(9, 15) : $urandom_range(0, 3);
      dens = $urandom_range(10, 100);
      configure($urandom_range(0, 1), $urandom_range(0, 3), N'($urandom), dec);
      repeat (300) begin
        @(negedge clk);
        for (int i = 0; i < N; i++) dif.in_valid[i] = ($urandom_range(1, 100) <= dens);
        dif.in_data   = {$urandom, $urandom};
        clear_overrun = ($urandom_range(0, 19) == 0);
        if ($urandom_range(0, 15) == 0) begin
          mode = $urandom_range(0, 1); sel_ch = CW'($urandom);
          ch_mask = N'($urandom); decim_log2 = DW'($urandom);
        end
        enable = ($urandom_range(0, 49) != 0);
      end
      clear_overrun = 0;
      idle(2);
    end

    idle(4);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
